// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU sharing slice: the opcode encoding seen by
//   the 8-function ALU (mux8to1) and the state encoding of the arbiter FSM
//   in alu_share_arb.
//   Opcode bit 2 drives ALU select i1, bit 1 drives i2, bit 0 drives i3.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mux8to1.sv
// mux8to1
//   Purely combinational 8-function ALU, N bits wide.
//   Ports:
//     a, b        in  N  operands (b ignored for the shift functions)
//     i1, i2, i3  in  1  function select, i1 is the MSB of the opcode
//     y           out N  result; no carry or flags
module mux8to1
  import alu_pkg::*;
#(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         i1,
  input  logic         i2,
  input  logic         i3,
  output logic [N-1:0] y
);

  logic [2:0] sel;

  assign sel = {i1, i2, i3};

  always_comb begin
    y = '0;
    case (sel)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_SHL:  y = {a[N-2:0], 1'b0};
      OP_SHR:  y = {1'b0, a[N-1:1]};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb
//   Two-requester round-robin arbiter and sequencer in front of a single
//   shared mux8to1 ALU. A winning request is latched, executed from the
//   latched registers, and its result returned with the requester id.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     req_valid[1:0]        per-requester request pending
//     req_ready[1:0]        per-requester accept strobe (one-hot or zero)
//     req0_op/a/b           requester 0 opcode and operands
//     req1_op/a/b           requester 1 opcode and operands
//     res_valid/res_ready   result handshake
//     res_data              registered ALU result
//     res_id                requester that issued res_data
//     busy                  FSM not in IDLE
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int N = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [2:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [2:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_id,
  output logic         busy
);

  state_t       state;
  logic         last;
  logic [2:0]   op_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic         id_q;

  logic         win_id;
  logic         accept;
  logic [2:0]   win_op;
  logic [N-1:0] win_a;
  logic [N-1:0] win_b;
  logic [N-1:0] alu_y;

  // Round-robin: on contention the requester that did not win last time
  // goes; otherwise the single valid requester wins.
  always_comb begin
    win_id = req_valid[1];
    if (req_valid == 2'b11) begin
      win_id = ~last;
    end
  end

  // Accept is suppressed while rst is high so no grant is seen for a
  // request that the reset edge will not latch.
  assign accept = (state == S_IDLE) && !rst && (req_valid != 2'b00);

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[win_id] = 1'b1;
    end
  end

  always_comb begin
    win_op = req0_op;
    win_a  = req0_a;
    win_b  = req0_b;
    if (win_id) begin
      win_op = req1_op;
      win_a  = req1_a;
      win_b  = req1_b;
    end
  end

  // The ALU only ever sees latched operands, so requester inputs may change
  // freely once accepted.
  mux8to1 #(
    .N(N)
  ) u_alu (
    .a (a_q),
    .b (b_q),
    .i1(op_q[2]),
    .i2(op_q[1]),
    .i3(op_q[0]),
    .y (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      last      <= 1'b1;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= win_op;
            a_q   <= win_a;
            b_q   <= win_b;
            id_q  <= win_id;
            last  <= win_id;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_data  <= alu_y;
          res_id    <= id_q;
          res_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer for the shared 8-function ALU (`mux8to1`). It accepts operation requests from two independent clients over valid/ready handshakes and grants the ALU round-robin. It drives the ALU select lines and operands from registered values, then returns a registered result tagged with the requester id. It sits between the client blocks and the single ALU instance, so the ALU itself stays purely combinational.

## Interface
Parameters:
- `N`, 9, operand/result width; must be ≥ 2, matching the ALU width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  2  bit k = requester k has a request pending.
- `req_ready`  out  2  bit k = request k accepted this cycle; at most one bit set.
- `req0_op`, `req1_op`  in  3 each  opcode; bit2→`i1`, bit1→`i2`, bit0→`i3`.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  N each  operands.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  N  ALU result.
- `res_id`  out  1  requester that issued the result.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Opcodes: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 SHL a by 1 (LSB←0), 111 SHR a by 1 (MSB←0). `b` is ignored for shifts.
- FSM, 2-bit state, three states:
  - IDLE: if any `req_valid`, pick a winner, pulse its `req_ready` for that cycle (combinational from state and `req_valid`), and latch the winner's op/a/b/id. Go to EXEC. Otherwise stay in IDLE.
  - EXEC: the ALU sees only latched registers. Register the ALU output into `res_data` and the id into `res_id`, set `res_valid`=1, go to RESP.
  - RESP: hold `res_valid`, `res_data` and `res_id` stable until `res_valid && res_ready`. On that edge clear `res_valid` and go to IDLE. No new request is accepted in RESP.
- Round-robin arbitration:
  - Register `last` holds the id of the last accepted requester; it resets to 1, so requester 0 wins first.
  - If both requesters are valid, the winner is `~last`. If only one is valid, it wins.
  - `last` updates only on acceptance.
- Requesters must hold their op/operands stable while `req_valid` is high and unaccepted. Inputs are sampled only on the accept cycle; later changes have no effect.
- Result width is exactly N. No carry or flags are produced.

## Timing
- Reset values: `req_ready`=0, `res_valid`=0, `res_data`=0, `res_id`=0, `busy`=0, state IDLE, `last`=1.
- Accept at edge T (`req_ready` high in cycle T). `res_valid` rises after edge T+1, giving a latency of 2 cycles.
- Minimum initiation interval is 3 cycles: accept, exec, and a response handshake in the first RESP cycle.
- `res_ready` held high: `res_valid` is high for exactly one cycle per result.
- `res_ready` low: the result is held indefinitely. Pending requests keep waiting; none is dropped.
- `rst` asserted in any state: the in-flight transaction is discarded, all outputs return to reset values at the next edge, and `last` returns to 1.
- `req_valid` dropped before acceptance: no effect and no grant recorded.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams `OP_AND`…`OP_SHR` (3 bits);
  - state encoding `S_IDLE`=0, `S_EXEC`=1, `S_RESP`=2.
- One sub-module: the existing `mux8to1 #(.N(N))`, instantiated once and fed from the latched registers (`i1`/`i2`/`i3` = `op_q[2]`/`op_q[1]`/`op_q[0]`).
- Remaining logic lives in the top module: FSM, arbiter, latches and output register.

## Test plan
All values below use N=9.
- Reset, then a single request: req0 op=000, a=0x0F3, b=0x055 → `req_ready`=01 in the first cycle; two cycles later `res_valid`=1, `res_data`=0x051, `res_id`=0.
- Op sweep on req1 with a=0x0F3, b=0x055, `res_ready`=1:
  - OR→0x0F7, NAND→0x1AE, NOR→0x108;
  - XOR→0x0A6, XNOR→0x159;
  - SHL→0x1E6, SHR→0x079;
  - every result has `res_id`=1.
- Both `req_valid`=11 held continuously, `res_ready`=1 → grants alternate 0,1,0,1 after reset. Each grant is one cycle wide and they are spaced 3 cycles apart.
- `res_ready`=0 for 5 cycles with req1 pending → `res_data`/`res_id` stay stable and `req_ready` stays 00. After `res_ready`=1, return to IDLE, then req1 is granted.
- `rst` pulsed in EXEC → next cycle all outputs 0 and `busy`=0. The discarded transaction produces no result, and the next grant with both valid goes to requester 0.
- Operand change after accept: req0 accepted with a=0x001 SHL, then a changes to 0x100 → result is 0x002.
